cmos_capture_rgb565: RTL and testbench

- Sits directly downstream of the OV5640 configuration block.
- Once cfg_done is high, it samples the camera DVP bus (VSYNC, HREF, 8-bit data) in the pixel-clock domain and discards the first SKIP_FRAMES frames while the sensor settles.
- It packs byte pairs into RGB565 pixels and emits a valid-qualified pixel stream with start-of-frame and end-of-line markers for the video buffer writer.
- It also checks each line and frame against CAM_HSIZE/CAM_VSIZE and reports sticky geometry errors.

---
 rtl/cmos_capture_rgb565.sv | 162 ++++++++++++++++
 tb/tb_cmos_capture_rgb565.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cmos_capture_rgb565.sv
// rtl/cmos_capture_rgb565.sv - OV5640 DVP capture, RGB565 packing and geometry checks
module cmos_capture_rgb565 #(
  parameter logic [7:0] SKIP_FRAMES = 8'd10,
  parameter logic       VS_POL      = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_done,
  input  logic        cmos_vs_i,
  input  logic        cmos_href_i,
  input  logic [7:0]  cmos_data_i,
  input  logic [15:0] CAM_HSIZE,
  input  logic [15:0] CAM_VSIZE,
  output logic [15:0] pix_data,
  output logic        pix_vld,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [7:0]  frame_cnt,
  output logic        err_hsize,
  output logic        err_vsize,
  output logic        err_odd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SYNC, SKIP, RUN} state_t;

  state_t      state;
  logic        vs_r1, vs_r2, href_r1, href_r2;
  logic [7:0]  data_r1;
  logic [7:0]  hi;
  logic        phase;
  logic [15:0] x, y;
  logic [7:0]  skip_cnt;

  logic        vs_edge, href_rise, href_fall, line_close, eff_phase;
  logic [15:0] y_closed;

  // Register the DVP bus once, and keep a second copy of the sync lines for edges
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_r1   <= 1'b0;
      vs_r2   <= 1'b0;
      href_r1 <= 1'b0;
      href_r2 <= 1'b0;
      data_r1 <= 8'd0;
    end else begin
      vs_r1   <= cmos_vs_i;
      vs_r2   <= vs_r1;
      href_r1 <= cmos_href_i;
      href_r2 <= href_r1;
      data_r1 <= cmos_data_i;
    end
  end

  // Edge detection; a frame boundary arriving with HREF still high also closes the line
  always_comb begin
    vs_edge    = (vs_r1 == VS_POL) && (vs_r2 != VS_POL);
    href_rise  = href_r1 & ~href_r2;
    href_fall  = ~href_r1 & href_r2;
    line_close = href_fall | (vs_edge & href_r1);
    eff_phase  = href_rise ? 1'b0 : phase;
    y_closed   = line_close ? (y + 16'd1) : y;
  end

  // Sequencer, byte packer, line/frame counters and sticky geometry checks
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      busy      <= 1'b0;
      pix_data  <= 16'd0;
      pix_vld   <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      frame_cnt <= 8'd0;
      err_hsize <= 1'b0;
      err_vsize <= 1'b0;
      err_odd   <= 1'b0;
      hi        <= 8'd0;
      phase     <= 1'b0;
      x         <= 16'd0;
      y         <= 16'd0;
      skip_cnt  <= 8'd0;
    end else begin
      pix_vld <= 1'b0;
      pix_sof <= 1'b0;
      pix_eol <= 1'b0;
      if (!cfg_done) begin
        // Losing configuration abandons capture; counts and sticky flags survive
        state    <= IDLE;
        busy     <= 1'b0;
        phase    <= 1'b0;
        x        <= 16'd0;
        y        <= 16'd0;
        skip_cnt <= 8'd0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (vs_edge) begin
              skip_cnt <= 8'd0;
              phase    <= 1'b0;
              x        <= 16'd0;
              y        <= 16'd0;
              if (SKIP_FRAMES != 8'd0) begin
                state <= SKIP;
              end else begin
                state <= RUN;
                busy  <= 1'b1;
              end
            end
          end
          SKIP: begin
            if (vs_edge) begin
              if (skip_cnt == 8'(SKIP_FRAMES - 8'd1)) begin
                state <= RUN;
                busy  <= 1'b1;
                phase <= 1'b0;
                x     <= 16'd0;
                y     <= 16'd0;
              end else begin
                skip_cnt <= skip_cnt + 8'd1;
              end
            end
          end
          RUN: begin
            if (line_close) begin
              if (phase) err_odd <= 1'b1;
              if (x != CAM_HSIZE) err_hsize <= 1'b1;
              if (y == 16'hFFFF) err_vsize <= 1'b1;
              phase <= 1'b0;
              x     <= 16'd0;
              y     <= y + 16'd1;
            end else if (href_r1) begin
              if (!eff_phase) begin
                hi    <= data_r1;
                phase <= 1'b1;
              end else begin
                pix_data <= {hi, data_r1};
                pix_vld  <= 1'b1;
                pix_sof  <= (x == 16'd0) && (y == 16'd0);
                pix_eol  <= (x == CAM_HSIZE - 16'd1);
                if (x == 16'hFFFF) err_hsize <= 1'b1;
                x     <= x + 16'd1;
                phase <= 1'b0;
              end
            end
            if (vs_edge) begin
              // Only frames of the expected height are counted
              if (y_closed != CAM_VSIZE) err_vsize <= 1'b1;
              else if (y_closed != 16'd0) frame_cnt <= frame_cnt + 8'd1;
              phase <= 1'b0;
              x     <= 16'd0;
              y     <= 16'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// tb/tb_cmos_capture_rgb565.sv - scoreboard bench for cmos_capture_rgb565
module tb_cmos_capture_rgb565;

  logic        clk_i = 1'b0;
  logic        rst_i, cfg_done, cmos_vs_i, cmos_href_i;
  logic [7:0]  cmos_data_i;
  logic [15:0] CAM_HSIZE, CAM_VSIZE;
  logic [15:0] pix_data;
  logic        pix_vld, pix_sof, pix_eol, err_hsize, err_vsize, err_odd, busy;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int lat_n = -100;
  int abcd_cyc = -1;
  logic [17:0] sb_q[$];
  logic [7:0]  lb[0:7];

  cmos_capture_rgb565 #(.SKIP_FRAMES(8'd2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_done(cfg_done),
    .cmos_vs_i(cmos_vs_i), .cmos_href_i(cmos_href_i), .cmos_data_i(cmos_data_i),
    .CAM_HSIZE(CAM_HSIZE), .CAM_VSIZE(CAM_VSIZE),
    .pix_data(pix_data), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_cnt(frame_cnt), .err_hsize(err_hsize), .err_vsize(err_vsize),
    .err_odd(err_odd), .busy(busy)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every presented pixel is popped from the scoreboard and compared
  always @(negedge clk_i) begin
    if (pix_vld === 1'b1) begin
      if (pix_data == 16'hABCD) abcd_cyc = cyc;
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pixel: got data=%04h sof=%0b eol=%0b expected none", pix_data, pix_sof, pix_eol);
      end else begin
        chk("pixel {sof,eol,data}", {14'd0, pix_sof, pix_eol, pix_data}, {14'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic fill_std();
    for (int i = 0; i < 8; i++) lb[i] = 8'(i);
  endtask

  task automatic push_pix(input logic [15:0] d, input logic sof, input logic eol);
    sb_q.push_back({sof, eol, d});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      cmos_href_i = 1'b0;
      cmos_data_i = 8'd0;
    end
  endtask

  task automatic drive_line(input int nbytes, input bit exp_en, input bit first);
    if (exp_en)
      for (int p = 0; p < nbytes / 2; p++)
        push_pix({lb[2*p], lb[2*p+1]}, first && (p == 0), p == 3);
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk_i); #1;
      cmos_href_i = 1'b1;
      cmos_data_i = lb[i];
      if (i == 1 && lb[1] == 8'hCD) lat_n = cyc + 1;
    end
    idle(4);
  endtask

  task automatic drive_frame(input int nlines, input bit exp_en);
    for (int l = 0; l < nlines; l++) begin
      fill_std();
      drive_line(8, exp_en, l == 0);
    end
  endtask

  task automatic vs_blank();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      cmos_vs_i = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      cmos_vs_i = 1'b0;
    end
  endtask

  initial begin
    rst_i = 1'b1; cfg_done = 1'b0; cmos_vs_i = 1'b0; cmos_href_i = 1'b0;
    cmos_data_i = 8'd0; CAM_HSIZE = 16'd4; CAM_VSIZE = 16'd3;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset pix_vld", pix_vld, 0);
    chk("reset pix_data", pix_data, 0);
    chk("reset frame_cnt", frame_cnt, 0);
    chk("reset errors", {err_odd, err_hsize, err_vsize}, 0);
    chk("reset busy", busy, 0);

    @(posedge clk_i); #1;
    rst_i = 1'b0; cfg_done = 1'b1;
    idle(4);

    // Two skipped frames, then two output frames
    vs_blank(); drive_frame(3, 0);
    vs_blank();
    chk("busy in skip", busy, 0);
    drive_frame(3, 0);
    vs_blank();
    chk("busy in run", busy, 1);
    drive_frame(3, 1);
    vs_blank();
    chk("frame_cnt after frame 3", frame_cnt, 1);
    drive_frame(3, 1);
    vs_blank();
    chk("frame_cnt after frame 4", frame_cnt, 2);
    chk("errors clean", {err_odd, err_hsize, err_vsize}, 0);

    // Latency frame: first line carries 0xAB,0xCD
    lb[0] = 8'hAB; lb[1] = 8'hCD;
    for (int i = 2; i < 8; i++) lb[i] = 8'(i - 1);
    drive_line(8, 1, 1);
    fill_std(); drive_line(8, 1, 0);
    fill_std(); drive_line(8, 1, 0);
    vs_blank();
    chk("latency edges after CD", abcd_cyc - lat_n, 1);
    chk("frame_cnt after latency frame", frame_cnt, 3);

    // Odd 7-byte line in an otherwise good frame
    fill_std();
    push_pix(16'h0001, 1, 0); push_pix(16'h0203, 0, 0); push_pix(16'h0405, 0, 0);
    drive_line(7, 0, 1);
    drive_line(8, 1, 0);
    drive_line(8, 1, 0);
    vs_blank();
    chk("err_odd after 7-byte line", err_odd, 1);
    chk("err_hsize after 7-byte line", err_hsize, 1);
    chk("err_vsize still clear", err_vsize, 0);
    chk("frame_cnt after odd-line frame", frame_cnt, 4);

    // Short frame, then a good frame
    drive_frame(2, 1);
    vs_blank();
    chk("err_vsize after short frame", err_vsize, 1);
    chk("frame_cnt held on short frame", frame_cnt, 4);
    drive_frame(3, 1);
    vs_blank();
    chk("frame_cnt after recovery", frame_cnt, 5);
    chk("sticky odd/hsize", {err_odd, err_hsize}, 2'b11);

    // cfg_done dropped mid-line: 0x0203 would be presented on the drop edge
    push_pix(16'h0001, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      cmos_href_i = 1'b1; cmos_data_i = 8'(i);
    end
    @(posedge clk_i); #1;
    cfg_done = 1'b0; cmos_data_i = 8'd4;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("pix_vld after cfg drop", pix_vld, 0);
    chk("busy after cfg drop", busy, 0);
    for (int i = 5; i < 8; i++) begin
      @(posedge clk_i); #1;
      cmos_data_i = 8'(i);
    end
    idle(6);
    cfg_done = 1'b1;
    idle(4);
    vs_blank(); drive_frame(3, 0);
    vs_blank(); drive_frame(3, 0);
    vs_blank();
    chk("busy after re-sync", busy, 1);
    drive_frame(3, 1);
    vs_blank();
    chk("frame_cnt after re-sync frame", frame_cnt, 6);

    // Reset mid-line
    push_pix(16'h0001, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      cmos_href_i = 1'b1; cmos_data_i = 8'(i);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1; cmos_data_i = 8'd4;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("mid-frame reset pix_vld", pix_vld, 0);
    chk("mid-frame reset pix_data", pix_data, 0);
    chk("mid-frame reset frame_cnt", frame_cnt, 0);
    chk("mid-frame reset errors", {err_odd, err_hsize, err_vsize}, 0);
    chk("mid-frame reset busy", busy, 0);
    chk("mid-frame reset sof/eol", {pix_sof, pix_eol}, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(6);
    chk("scoreboard drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
